imm_ext_pipe: RTL and testbench
===============================

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter DATA_W, default 64, datapath width; legal values 32 and 64.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  stage 1 can accept a request this cycle.
REQ-006 in_instr  input  26  instruction bits [25:0].
REQ-007 in_op  input  3  immediate mode: 000 I, 001 D, 010 CB, 011 B, 100 MOVZ, 101 MOVK, 110 MOVN, 111 I-LSL12.
REQ-008 in_old  input  DATA_W  current destination register value, used by MOVK only.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_imm  output  DATA_W  extended immediate.
REQ-012 out_illegal  output  1  the request was illegal; out_imm is 0.

Function
REQ-013 Fields: immI=[21:10], immD=[20:12] signed, immCB=[23:5] signed, immB=[25:0] signed, imm16=[20:5], hw=[22:21].
REQ-014 Results are computed at 64 bits and truncated to DATA_W: I zero-extends immI; I-LSL12 gives zext(immI)<<12; D sign-extends immD; CB gives sext(immCB)<<2; B gives sext(immB)<<2.
REQ-015 MOVZ gives zext(imm16)<<(16*hw); MOVN gives ~(zext(imm16)<<(16*hw)); MOVK gives in_old with halfword hw replaced by imm16.
REQ-016 A MOVZ/MOVK/MOVN request with 16*hw >= DATA_W is illegal.
REQ-017 The pipeline has two register stages; stage 1 captures in_instr, in_op and in_old, and stage 2 captures out_imm and out_illegal.
REQ-018 Latency is exactly 2 cycles from the in_valid&&in_ready edge to out_valid when out_ready is held high; throughput is 1 request per cycle.
REQ-019 A transfer occurs on each edge where valid&&ready is high; no request is dropped or duplicated, and results leave in order.
REQ-020 in_ready = !s1_valid || (s1 advances this cycle); s1 advances when !s2_valid || out_ready.
REQ-021 While out_valid && !out_ready, out_imm and out_illegal hold stable; bubbles collapse, so a full pipe stalled by the consumer holds 2 requests.
REQ-022 in_ready does not depend combinationally on in_valid; it does depend on out_ready.
REQ-023 Transfers on both sides in the same cycle advance the pipe without loss.

Reset
REQ-024 While Reset is high: s1_valid=0, s2_valid=0, out_valid=0, out_imm=0, out_illegal=0; in_ready is 1 on the first cycle after release.
REQ-025 A Reset asserted mid-operation discards all in-flight requests; the handshake rules apply on the next cycle, with no spurious out_valid.

Configuration
REQ-026 Macro IMM_EXT_MOVK_EN: when defined, MOVK and MOVN behave per REQ-015.
REQ-027 When IMM_EXT_MOVK_EN is undefined, ops 101 and 110 are illegal (out_illegal=1, out_imm=0), in_old is ignored, and no in_old storage is instantiated.

Structure
REQ-028 Package imm_ext_pkg holds the op-code localparams (OP_I, OP_D, OP_CB, OP_B, OP_MOVZ, OP_MOVK, OP_MOVN, OP_ILSL12) and the field bit positions.
REQ-029 A combinational sub-module imm_ext_core(op, instr, old -> imm, illegal) sits between stage 1 and stage 2; the two pipeline stages live in imm_ext_pipe.

Verification
REQ-030 DATA_W=64, CB, immCB=19'h7FFFF -> out_imm 64'hFFFF_FFFF_FFFF_FFFC, out_illegal=0, 2 cycles after acceptance.
REQ-031 MOVZ, imm16=16'h1234, hw=2 -> 64'h0000_1234_0000_0000; MOVN with the same fields -> 64'hFFFF_EDCB_FFFF_FFFF.
REQ-032 With IMM_EXT_MOVK_EN: MOVK, in_old=64'hAAAA_BBBB_CCCC_DDDD, imm16=16'h1234, hw=1 -> 64'hAAAA_BBBB_1234_DDDD. Without it: out_illegal=1, out_imm=0.
REQ-033 DATA_W=32, MOVZ, hw=2 -> out_illegal=1, out_imm=32'h0; I-LSL12 with immI=12'hFFF -> 32'h00FF_F000.
REQ-034 Drive 4 back-to-back requests with out_ready=0 -> 2 accepted, then in_ready=0. Raise out_ready -> all 4 results appear in order with no loss or duplication.
REQ-035 Assert Reset for 1 cycle while 2 requests are in flight -> out_valid=0 afterwards, no stale result ever appears, and in_ready=1 on the cycle after release.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared op-codes, instruction field positions and helpers for the immediate extension pipe.
package imm_ext_pkg;

    localparam logic [2:0] OP_I      = 3'b000;
    localparam logic [2:0] OP_D      = 3'b001;
    localparam logic [2:0] OP_CB     = 3'b010;
    localparam logic [2:0] OP_B      = 3'b011;
    localparam logic [2:0] OP_MOVZ   = 3'b100;
    localparam logic [2:0] OP_MOVK   = 3'b101;
    localparam logic [2:0] OP_MOVN   = 3'b110;
    localparam logic [2:0] OP_ILSL12 = 3'b111;

    localparam int IMMI_LSB  = 10;
    localparam int IMMI_MSB  = 21;
    localparam int IMMD_LSB  = 12;
    localparam int IMMD_MSB  = 20;
    localparam int IMMCB_LSB = 5;
    localparam int IMMCB_MSB = 23;
    localparam int IMMB_LSB  = 0;
    localparam int IMMB_MSB  = 25;
    localparam int IMM16_LSB = 5;
    localparam int IMM16_MSB = 20;
    localparam int HW_LSB    = 21;
    localparam int HW_MSB    = 22;

    function automatic logic is_wide_move(input logic [2:0] op);
        return (op == OP_MOVZ) || (op == OP_MOVK) || (op == OP_MOVN);
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extractor/extender; MOVK/MOVN exist only with IMM_EXT_MOVK_EN defined.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]        op,
    input  logic [25:0]       instr,
    input  logic [DATA_W-1:0] old,
    output logic [DATA_W-1:0] imm,
    output logic              illegal
);

    logic [11:0] imm_i;
    logic [8:0]  imm_d;
    logic [18:0] imm_cb;
    logic [25:0] imm_b;
    logic [15:0] imm16;
    logic [1:0]  hw;
    logic [5:0]  shamt;
    logic [63:0] mov_val;
    logic [63:0] res;
    logic        hw_oob;
    logic        bad;

    assign imm_i   = instr[IMMI_MSB:IMMI_LSB];
    assign imm_d   = instr[IMMD_MSB:IMMD_LSB];
    assign imm_cb  = instr[IMMCB_MSB:IMMCB_LSB];
    assign imm_b   = instr[IMMB_MSB:IMMB_LSB];
    assign imm16   = instr[IMM16_MSB:IMM16_LSB];
    assign hw      = instr[HW_MSB:HW_LSB];
    assign shamt   = {hw, 4'b0000};
    assign mov_val = 64'(imm16) << shamt;
    // A halfword slot beyond the datapath cannot be written, so the move is rejected.
    assign hw_oob  = (32'(hw) * 32'd16) >= 32'(DATA_W);

`ifdef IMM_EXT_MOVK_EN
    logic [63:0] old64;
    logic [63:0] hw_mask;
    assign old64   = 64'(old);
    assign hw_mask = 64'h0000_0000_0000_FFFF << shamt;
`else
    logic unused_old;
    assign unused_old = ^old;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        res = '0;
        bad = 1'b0;
        case (op)
            OP_I:      res = {52'b0, imm_i};
            OP_ILSL12: res = {40'b0, imm_i, 12'b0};
            OP_D:      res = {{55{imm_d[8]}}, imm_d};
            OP_CB:     res = {{43{imm_cb[18]}}, imm_cb, 2'b00};
            OP_B:      res = {{36{imm_b[25]}}, imm_b, 2'b00};
            OP_MOVZ:   res = mov_val;
`ifdef IMM_EXT_MOVK_EN
            OP_MOVN:   res = ~mov_val;
            OP_MOVK:   res = (old64 & ~hw_mask) | mov_val;
`else
            OP_MOVN:   bad = 1'b1;
            OP_MOVK:   bad = 1'b1;
`endif
            default:   bad = 1'b1;
        endcase
        if (is_wide_move(op) && hw_oob) begin
            bad = 1'b1;
        end
        if (bad) begin
            res = '0;
        end
    end

    assign imm     = res[DATA_W-1:0];
    assign illegal = bad;

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready pipe around imm_ext_core; IMM_EXT_MOVK_EN adds the in_old stage-1 register.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [25:0]       in_instr,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_old,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_illegal
);

    logic              s1_valid;
    logic [25:0]       s1_instr;
    logic [2:0]        s1_op;
    logic [DATA_W-1:0] core_old;
    logic [DATA_W-1:0] core_imm;
    logic              core_illegal;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_imm;
    logic              s2_illegal;
    logic              s1_advance;

    // Stage 1 moves whenever stage 2 is empty or being drained, so bubbles collapse.
    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: payload registers carry no reset; they are only consumed while s1_valid is set.
    always_ff @(posedge CLK) begin
        if (in_valid && in_ready) begin
            s1_instr <= in_instr;
            s1_op    <= in_op;
        end
    end

`ifdef IMM_EXT_MOVK_EN
    logic [DATA_W-1:0] s1_old;
    always_ff @(posedge CLK) begin
        if (in_valid && in_ready) begin
            s1_old <= in_old;
        end
    end
    assign core_old = s1_old;
`else
    logic unused_in_old;
    assign unused_in_old = ^in_old;
    assign core_old      = '0;
`endif

    imm_ext_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .op      (s1_op),
        .instr   (s1_instr),
        .old     (core_old),
        .imm     (core_imm),
        .illegal (core_illegal)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            s2_valid   <= 1'b0;
            s2_imm     <= '0;
            s2_illegal <= 1'b0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_imm     <= core_imm;
                s2_illegal <= core_illegal;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_imm     = s2_imm;
    assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe at DATA_W=64 and DATA_W=32 (shared stimulus).
module tb_imm_ext_pipe;
    import imm_ext_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic [25:0] in_instr;
    logic [2:0]  in_op;
    logic [63:0] in_old;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_imm;
    logic        out_illegal;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] out_imm32;
    logic        out_illegal32;
    logic [31:0] in_old32;

    int          n_chk = 0;
    int          n_err = 0;
    logic        rec_en = 1'b0;
    logic [63:0] got[$];

    assign in_old32 = in_old[31:0];

    always #5 CLK = ~CLK;

    imm_ext_pipe #(.DATA_W(64)) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_op       (in_op),
        .in_old      (in_old),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    imm_ext_pipe #(.DATA_W(32)) dut32 (
        .CLK         (CLK),
        .Reset       (Reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready32),
        .in_instr    (in_instr),
        .in_op       (in_op),
        .in_old      (in_old32),
        .out_valid   (out_valid32),
        .out_ready   (out_ready),
        .out_imm     (out_imm32),
        .out_illegal (out_illegal32)
    );

    function automatic logic [25:0] f_mov(input logic [15:0] v, input logic [1:0] hw);
        logic [25:0] r = '0;
        r[20:5]  = v;
        r[22:21] = hw;
        return r;
    endfunction

    function automatic logic [25:0] f_i(input logic [11:0] v);
        logic [25:0] r = '0;
        r[21:10] = v;
        return r;
    endfunction

    function automatic logic [25:0] f_d(input logic [8:0] v);
        logic [25:0] r = '0;
        r[20:12] = v;
        return r;
    endfunction

    function automatic logic [25:0] f_cb(input logic [18:0] v);
        logic [25:0] r = '0;
        r[23:5] = v;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, logging any output transfer at the rising edge in between.
    task automatic step();
        if (rec_en && out_valid && out_ready) got.push_back(out_imm);
        @(negedge CLK);
    endtask

    task automatic run_one(input string tag, input logic [2:0] op, input logic [25:0] instr,
                           input logic [63:0] old, input logic [63:0] e64, input logic il64,
                           input logic chk32, input logic [31:0] e32, input logic il32);
        in_valid = 1'b1;
        in_op    = op;
        in_instr = instr;
        in_old   = old;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        #1;
        check({tag, "_lat1"}, 64'(out_valid), 64'd0);
        step();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_imm"}, out_imm, e64);
        check({tag, "_illegal"}, 64'(out_illegal), 64'(il64));
        if (chk32) begin
            check({tag, "_imm32"}, 64'(out_imm32), 64'(e32));
            check({tag, "_illegal32"}, 64'(out_illegal32), 64'(il32));
        end
        step();
    endtask

    task automatic present(input logic [2:0] op, input logic [25:0] instr);
        in_valid = 1'b1;
        in_op    = op;
        in_instr = instr;
        in_old   = '0;
    endtask

    initial begin
        Reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_op     = OP_I;
        in_old    = '0;
        out_ready = 1'b1;

        // Reset state
        @(negedge CLK);
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_imm", out_imm, 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        Reset = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        step();

        // Field extraction and extension
        run_one("cb_neg", OP_CB, f_cb(19'h7FFFF), 64'd0,
                64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run_one("cb_pos", OP_CB, f_cb(19'h00001), 64'd0, 64'h4, 1'b0, 1'b0, 32'h0, 1'b0);
        run_one("i_zext", OP_I, f_i(12'hABC) | 26'h200_0000, 64'd0,
                64'h0ABC, 1'b0, 1'b1, 32'h0ABC, 1'b0);
        run_one("ilsl12", OP_ILSL12, f_i(12'hFFF), 64'd0,
                64'h0000_0000_00FF_F000, 1'b0, 1'b1, 32'h00FF_F000, 1'b0);
        run_one("d_neg", OP_D, f_d(9'h100), 64'd0, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 1'b0, 32'h0, 1'b0);
        run_one("d_pos", OP_D, f_d(9'h0FF), 64'd0, 64'h00FF, 1'b0, 1'b0, 32'h0, 1'b0);
        run_one("b_neg", OP_B, 26'h200_0000, 64'd0, 64'hFFFF_FFFF_F800_0000, 1'b0,
                1'b1, 32'hF800_0000, 1'b0);
        run_one("movz_hw2", OP_MOVZ, f_mov(16'h1234, 2'd2), 64'd0,
                64'h0000_1234_0000_0000, 1'b0, 1'b1, 32'h0, 1'b1);
        run_one("movz_hw3", OP_MOVZ, f_mov(16'hABCD, 2'd3), 64'd0,
                64'hABCD_0000_0000_0000, 1'b0, 1'b1, 32'h0, 1'b1);
        run_one("movz_hw1", OP_MOVZ, f_mov(16'h5A5A, 2'd1), 64'd0,
                64'h0000_0000_5A5A_0000, 1'b0, 1'b1, 32'h5A5A_0000, 1'b0);
`ifdef IMM_EXT_MOVK_EN
        run_one("movn_hw2", OP_MOVN, f_mov(16'h1234, 2'd2), 64'd0,
                64'hFFFF_EDCB_FFFF_FFFF, 1'b0, 1'b1, 32'h0, 1'b1);
        run_one("movk_hw1", OP_MOVK, f_mov(16'h1234, 2'd1), 64'hAAAA_BBBB_CCCC_DDDD,
                64'hAAAA_BBBB_1234_DDDD, 1'b0, 1'b1, 32'h1234_DDDD, 1'b0);
`else
        run_one("movn_hw2", OP_MOVN, f_mov(16'h1234, 2'd2), 64'd0,
                64'h0, 1'b1, 1'b1, 32'h0, 1'b1);
        run_one("movk_hw1", OP_MOVK, f_mov(16'h1234, 2'd1), 64'hAAAA_BBBB_CCCC_DDDD,
                64'h0, 1'b1, 1'b1, 32'h0, 1'b1);
`endif

        // Backpressure: two requests fill the pipe, then in_ready drops
        out_ready = 1'b0;
        got.delete();
        rec_en = 1'b1;
        present(OP_MOVZ, f_mov(16'h1111, 2'd0));
        #1;
        check("bp_rdy_a", 64'(in_ready), 64'd1);
        step();
        present(OP_MOVZ, f_mov(16'h2222, 2'd1));
        #1;
        check("bp_rdy_b", 64'(in_ready), 64'd1);
        step();
        present(OP_I, f_i(12'h333));
        #1;
        check("bp_full_rdy", 64'(in_ready), 64'd0);
        check("bp_full_valid", 64'(out_valid), 64'd1);
        check("bp_full_imm", out_imm, 64'h1111);
        step();
        step();
        #1;
        check("bp_hold_rdy", 64'(in_ready), 64'd0);
        check("bp_hold_imm", out_imm, 64'h1111);
        out_ready = 1'b1;
        #1;
        check("bp_rdy_comb", 64'(in_ready), 64'd1);
        step();
        present(OP_D, f_d(9'h1FF));
        #1;
        check("bp_rdy_d", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        step();
        rec_en = 1'b0;
        check("bp_count", 64'(got.size()), 64'd4);
        check("bp_res0", (got.size() > 0) ? got[0] : 64'hDEAD, 64'h0000_0000_0000_1111);
        check("bp_res1", (got.size() > 1) ? got[1] : 64'hDEAD, 64'h0000_0000_2222_0000);
        check("bp_res2", (got.size() > 2) ? got[2] : 64'hDEAD, 64'h0000_0000_0000_0333);
        check("bp_res3", (got.size() > 3) ? got[3] : 64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF);

        // Mid-flight reset discards both in-flight requests
        out_ready = 1'b0;
        present(OP_MOVZ, f_mov(16'h5555, 2'd0));
        step();
        present(OP_MOVZ, f_mov(16'h6666, 2'd0));
        step();
        in_valid = 1'b0;
        #1;
        check("mr_pre_valid", 64'(out_valid), 64'd1);
        Reset = 1'b1;
        step();
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_imm", out_imm, 64'd0);
        check("mr_illegal", 64'(out_illegal), 64'd0);
        Reset = 1'b0;
        #1;
        check("mr_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        got.delete();
        rec_en = 1'b1;
        step();
        step();
        step();
        rec_en = 1'b0;
        check("mr_no_stale", 64'(got.size()), 64'd0);
        check("mr_valid_after", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
        $finish;
    end

endmodule
